// File: rtl/div_arbiter_if.sv
// Requester and divider-side signal bundle for div_arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface div_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_dividend;
  logic [NUM_REQ*DW-1:0] req_divisor;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_quotient;
  logic                  rsp_err;
  logic                  div_start;
  logic [DW-1:0]         div_dividend;
  logic [DW-1:0]         div_divisor;
  logic [DW-1:0]         div_quotient;
  logic                  div_complete;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_quotient, div_complete,
    output req_ready, rsp_valid, rsp_quotient, rsp_err, div_start, div_dividend, div_divisor
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_quotient, div_complete,
    input  req_ready, rsp_valid, rsp_quotient, rsp_err, div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one sequential divider between NUM_REQ requesters,
// with divide-by-zero short-circuit and a watchdog on divider completion.
module div_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic          clk,
  input logic          rst_n,
  div_arbiter_if.slave bus
);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d, owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]      dividend_q, dividend_d, divisor_q, divisor_d, quot_q, quot_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] rsp_valid;

  logic [DW-1:0] req_dvd [NUM_REQ];
  logic [DW-1:0] req_dvs [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_dvd[k] = bus.req_dividend[k*DW +: DW];
    assign req_dvs[k] = bus.req_divisor[k*DW +: DW];
  end

  // First valid requester at or after rr_q, wrapping.
  logic          found;
  logic [IW-1:0] win, idx;
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IW'((32'(rr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    err_d      = err_q;
    ready_d    = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          ready_d[win] = 1'b1;
          dividend_d   = req_dvd[win];
          divisor_d    = req_dvs[win];
          owner_d      = win;
          rr_d         = IW'((32'(win) + 1) % NUM_REQ);
          if (req_dvs[win] == '0) begin
            err_d   = 1'b1;
            quot_d  = '1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.div_complete) begin
          quot_d  = bus.div_quotient;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            quot_d  = '1;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      err_q      <= 1'b0;
      ready_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign bus.req_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_quotient = (state_q == RESP) ? quot_q : '0;
  assign bus.rsp_err      = (state_q == RESP) && err_q;
  assign bus.div_start    = (state_q == ISSUE);
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
endmodule
